argmax_unit: RTL and testbench
==============================

# argmax_unit

Classification stage downstream of the final fully-connected layer. Once that layer reports done, this block scans its packed output RAM (VEC signed fixed-point values per word) and returns the index and value of the largest logit. It walks words sequentially and lanes serially, one element per cycle, then reports the result with a one-cycle done pulse.

## Interface

**Parameters**
- NUM_CLASSES, 10: number of valid logits (1 or more).
- DATA_WIDTH, 16: bits per logit, signed two's complement.
- VEC, 16: logits per RAM word (power of two, 2 or more).
- VEC_DEPTH, ceil(NUM_CLASSES/VEC): number of RAM words scanned.
- ADDR_WIDTH, max(1, clog2(VEC_DEPTH)): RAM word address width.
- IDX_WIDTH, max(1, clog2(NUM_CLASSES)): class index width.

**Ports**
- clk, input, 1: single clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a scan; sampled only in IDLE.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when the results are updated.
- rdaddr, output, ADDR_WIDTH: output-RAM word read address.
- q, input, VEC*DATA_WIDTH: RAM read data, registered; valid one cycle after rdaddr. Lane i is q[i*DATA_WIDTH +: DATA_WIDTH].
- class_idx, output, IDX_WIDTH: argmax index, word*VEC + lane.
- max_val, output, DATA_WIDTH: logit at class_idx.

## Operation

**States:** IDLE, FETCH, LATCH, SCAN, FINISH.

- **IDLE**
  - If start is high, clear word_idx and go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH**
  - rdaddr = word_idx. It is driven from the registered word_idx in every state.
  - Next state is LATCH.
- **LATCH**
  - Capture q into an internal word register.
  - Clear lane_idx.
  - Next state is SCAN.
- **SCAN**
  - Handle lane lane_idx of the captured word, one lane per cycle.
  - Global element index g = word_idx*VEC + lane_idx.
  - If g == 0: load best_val and best_idx unconditionally.
  - If g > 0: replace best_val/best_idx only if the lane value is signed-greater than best_val.
  - On ties the lowest index wins.
  - Leave SCAN after the last lane of the word (VEC-1), or after g == NUM_CLASSES-1, whichever comes first. Lanes beyond NUM_CLASSES-1 are never compared.
  - If g == NUM_CLASSES-1, next state is FINISH.
  - Otherwise increment word_idx and go to FETCH.
- **FINISH**
  - Copy best_val/best_idx into the max_val/class_idx output registers.
  - done = 1.
  - Next state is IDLE.

**Rules**
- Comparison is full-width signed. No saturation or truncation; best_val is DATA_WIDTH bits.
- class_idx and max_val change only on the edge entering FINISH. They hold their value otherwise, including across later scans until their FINISH.
- A start pulse while busy is ignored: not queued, no effect.
- Reset (rst_n low) at any time:
  - state goes to IDLE;
  - busy, done, class_idx, max_val, rdaddr, word_idx, lane_idx, best_* all go to 0.
  - An aborted scan produces no done.
- The RAM contents must be stable for the duration of busy. The upstream layer must not write the RAM while busy.

## Timing

- **Reset values:** busy=0, done=0, rdaddr=0, class_idx=0, max_val=0.
- **Latency:** with start sampled at edge k, done is high in the cycle after edge k + 2*VEC_DEPTH + NUM_CLASSES.
  - Defaults (1 word, 10 classes): done is high after edge k+12.
  - NUM_CLASSES=20, VEC=16: k+24.
- Results are valid from the cycle in which done is high.
- busy rises on edge k. It falls on the edge after done, when the block re-enters IDLE.
- start may be re-asserted in the cycle after done falls. Back-to-back scans are separated by one IDLE cycle.
- rdaddr must be stable during FETCH and LATCH. q is sampled exactly once per word, in LATCH.

## Test plan

- **Default params, distinct max:** logits lanes 0..9 = {-5, 3, 100, 7, -128, 99, 0, 1, 2, 50}, lanes 10..15 = 0x7FFF.
  - Required: class_idx=2, max_val=100, done after edge k+12.
  - Lanes 10-15 must be ignored.
- **All-negative and ties:** logits {-300, -2, -2, -9, ...} (remaining lanes -1000).
  - Required: class_idx=1, max_val=-2.
  - Confirms signed compare and lowest-index tie-break.
- **Multi-word, NUM_CLASSES=20, VEC=16:** maximum 0x4000 at class 17, word 1 lane 1.
  - Required: class_idx=17, max_val=0x4000, rdaddr sequence 0 then 1, done at k+24.
- **Reset mid-scan:** pull rst_n low during SCAN of word 0.
  - Required: outputs immediately 0, no done pulse.
  - A following scan returns the correct result.
- **start while busy:** pulse start during SCAN.
  - Required: exactly one done pulse, latency unchanged.
  - Results hold until the next FINISH.
- **Back-to-back scans:** change the RAM contents between scans.
  - Required: the second result reflects the new data.
  - class_idx/max_val keep the first result until the second done.

Source files
------------

// File: rtl/argmax_unit.sv
// argmax_unit: serial argmax over a packed logit RAM, one lane per cycle.
// Result registers update on entry to FINISH, alongside a one-cycle done pulse.
module argmax_unit #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int VEC         = 16,
  parameter int VEC_DEPTH   = (NUM_CLASSES + VEC - 1) / VEC,
  parameter int ADDR_WIDTH  = (VEC_DEPTH > 1) ? $clog2(VEC_DEPTH) : 1,
  parameter int IDX_WIDTH   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_WIDTH-1:0]        rdaddr,
  input  logic [VEC*DATA_WIDTH-1:0]    q,
  output logic [IDX_WIDTH-1:0]         class_idx,
  output logic signed [DATA_WIDTH-1:0] max_val
);

  localparam int LANE_W = $clog2(VEC);
  localparam int G_W    = ADDR_WIDTH + LANE_W;
  localparam logic [G_W-1:0]    LAST_G    = G_W'(NUM_CLASSES - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VEC - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SCAN,
    FINISH
  } state_t;

  state_t                        state;
  logic [ADDR_WIDTH-1:0]         word_idx;
  logic [LANE_W-1:0]             lane_idx;
  logic [VEC*DATA_WIDTH-1:0]     word_q;
  logic signed [DATA_WIDTH-1:0]  best_val;
  logic [IDX_WIDTH-1:0]          best_idx;

  logic [G_W-1:0]                g;
  logic signed [DATA_WIDTH-1:0]  lane_val;
  logic                          take;
  logic                          last_lane;
  logic                          last_class;
  logic signed [DATA_WIDTH-1:0]  nxt_val;
  logic [IDX_WIDTH-1:0]          nxt_idx;

  // VEC is a power of two, so word*VEC + lane is a plain concatenation
  assign g          = {word_idx, lane_idx};
  assign lane_val   = word_q[int'(lane_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign last_lane  = (lane_idx == LAST_LANE);
  assign last_class = (g == LAST_G);

  // strict greater-than keeps the lowest index on ties
  assign take    = (g == '0) || (lane_val > best_val);
  assign nxt_val = take ? lane_val : best_val;
  assign nxt_idx = take ? IDX_WIDTH'(g) : best_idx;

  assign rdaddr = word_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      word_idx  <= '0;
      lane_idx  <= '0;
      word_q    <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      class_idx <= '0;
      max_val   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            word_idx <= '0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          state <= LATCH;
        end
        LATCH: begin
          word_q   <= q;
          lane_idx <= '0;
          state    <= SCAN;
        end
        SCAN: begin
          best_val <= nxt_val;
          best_idx <= nxt_idx;
          lane_idx <= lane_idx + 1'b1;
          if (last_class) begin
            class_idx <= nxt_idx;
            max_val   <= nxt_val;
            done      <= 1'b1;
            state     <= FINISH;
          end else if (last_lane) begin
            word_idx <= word_idx + 1'b1;
            state    <= FETCH;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_unit.sv
// tb_argmax_unit: directed scans on a 1-word and a 2-word instance.
// Expected results come from a reference argmax pushed at each start.
module tb_argmax_unit;

  localparam int DW = 16;
  localparam int V  = 16;

  typedef struct {
    int idx;
    int val;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic busy0, done0, busy1, done1;
  logic [0:0] rdaddr0, rdaddr1;
  logic [V*DW-1:0] q0, q1;
  logic [3:0] idx0;
  logic [4:0] idx1;
  logic [DW-1:0] val0, val1;
  logic [V*DW-1:0] mem0 [2];
  logic [V*DW-1:0] mem1 [2];

  exp_t sb[$];
  exp_t last0, last1;
  int total = 0;
  int bad = 0;

  argmax_unit u0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .busy(busy0), .done(done0), .rdaddr(rdaddr0),
    .q(q0), .class_idx(idx0), .max_val(val0)
  );

  argmax_unit #(.NUM_CLASSES(20), .DATA_WIDTH(DW), .VEC(V)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .busy(busy1), .done(done1), .rdaddr(rdaddr1),
    .q(q1), .class_idx(idx1), .max_val(val1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    q0 <= mem0[rdaddr0];
    q1 <= mem1[rdaddr1];
  end

  initial begin
    #3000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lanev(input logic [V*DW-1:0] w, input int l);
    logic signed [DW-1:0] t;
    t = w[l*DW +: DW];
    return int'(t);
  endfunction

  function automatic exp_t model(input int which);
    exp_t e;
    int n, v, bv, bi;
    n = which ? 20 : 10;
    bv = 0;
    bi = 0;
    for (int g = 0; g < n; g++) begin
      v = which ? lanev(mem1[g / V], g % V) : lanev(mem0[0], g);
      if (g == 0 || v > bv) begin
        bv = v;
        bi = g;
      end
    end
    e.idx = bi;
    e.val = bv;
    e.lat = which ? 2 * 2 + 20 : 2 * 1 + 10;
    return e;
  endfunction

  task automatic set0(input int l, input int v);
    mem0[0][l*DW +: DW] = DW'(v);
  endtask

  task automatic set1(input int g, input int v);
    mem1[g / V][(g % V)*DW +: DW] = DW'(v);
  endtask

  // Called aligned to a negedge; returns aligned to a negedge.
  task automatic scan(input string tag, input int which, input int rst_at,
                      input int stray_at, input int quiet);
    exp_t e, lst;
    int n, ndone;
    bit seen;
    logic d, b;
    lst = which ? last1 : last0;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    sb.push_back(model(which));
    n = 0;
    seen = 0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      start0 = 1'b0;
      start1 = 1'b0;
      if (n == stray_at) begin
        if (which) start1 = 1'b1; else start0 = 1'b1;
      end
      b = which ? busy1 : busy0;
      d = which ? done1 : done0;
      if (n == 1) chk({tag, "_busy_rise"}, 32'(b), 1);
      if (n == 3) begin
        chk({tag, "_hold_idx"}, which ? 32'(idx1) : 32'(idx0), lst.idx);
        chk({tag, "_hold_val"},
            which ? 32'($signed(val1)) : 32'($signed(val0)), lst.val);
      end
      if (which && rst_at == 0 && n == 2) chk({tag, "_rdaddr_w0"}, 32'(rdaddr1), 0);
      if (which && rst_at == 0 && n == 20) chk({tag, "_rdaddr_w1"}, 32'(rdaddr1), 1);
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_busy"}, 32'(which ? busy1 : busy0), 0);
        chk({tag, "_rst_done"}, 32'(which ? done1 : done0), 0);
        chk({tag, "_rst_rdaddr"}, 32'(which ? rdaddr1 : rdaddr0), 0);
        chk({tag, "_rst_idx0"}, 32'(idx0), 0);
        chk({tag, "_rst_val0"}, 32'($signed(val0)), 0);
        chk({tag, "_rst_idx1"}, 32'(idx1), 0);
        chk({tag, "_rst_val1"}, 32'($signed(val1)), 0);
        void'(sb.pop_back());
        last0 = '{0, 0, 0};
        last1 = '{0, 0, 0};
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (done0 || done1) ndone++;
        end
        chk({tag, "_no_done_after_abort"}, ndone, 0);
        return;
      end
      if (d) seen = 1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    e = sb.pop_front();
    if (seen) begin
      chk({tag, "_latency"}, n - 1, e.lat);
      chk({tag, "_class_idx"}, which ? 32'(idx1) : 32'(idx0), e.idx);
      chk({tag, "_max_val"},
          which ? 32'($signed(val1)) : 32'($signed(val0)), e.val);
      if (which) last1 = e; else last0 = e;
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(which ? done1 : done0), 0);
      chk({tag, "_busy_fall"}, 32'(which ? busy1 : busy0), 0);
      if (quiet > 0) begin
        ndone = 0;
        for (int i = 0; i < quiet; i++) begin
          @(negedge clk);
          if (which ? done1 : done0) ndone++;
        end
        chk({tag, "_single_done"}, ndone, 0);
      end
    end
  endtask

  initial begin
    int d1[10];
    int d2[4];
    last0 = '{0, 0, 0};
    last1 = '{0, 0, 0};
    mem0[0] = '0;
    mem0[1] = '0;
    mem1[0] = '0;
    mem1[1] = '0;

    // reset values
    repeat (2) @(negedge clk);
    chk("reset_busy0", 32'(busy0), 0);
    chk("reset_done0", 32'(done0), 0);
    chk("reset_rdaddr0", 32'(rdaddr0), 0);
    chk("reset_idx0", 32'(idx0), 0);
    chk("reset_val0", 32'($signed(val0)), 0);
    chk("reset_busy1", 32'(busy1), 0);
    chk("reset_idx1", 32'(idx1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // distinct max, ignored lanes hold 0x7FFF
    d1 = '{-5, 3, 100, 7, -128, 99, 0, 1, 2, 50};
    for (int i = 0; i < 10; i++) set0(i, d1[i]);
    for (int i = 10; i < 16; i++) set0(i, 32'h7FFF);
    scan("distinct", 0, 0, 0, 5);
    chk("distinct_const_idx", 32'(idx0), 2);
    chk("distinct_const_val", 32'($signed(val0)), 100);

    // all negative with a tie
    d2 = '{-300, -2, -2, -9};
    for (int i = 0; i < 16; i++) set0(i, i < 4 ? d2[i] : -1000);
    scan("negtie", 0, 0, 0, 5);
    chk("negtie_const_idx", 32'(idx0), 1);
    chk("negtie_const_val", 32'($signed(val0)), -2);

    // multi-word, max at class 17
    for (int g = 0; g < 32; g++) set1(g, g < 20 ? g * 10 - 100 : 32'h7FFF);
    set1(5, 32'h3FFF);
    set1(17, 32'h4000);
    scan("multi", 1, 0, 0, 5);
    chk("multi_const_idx", 32'(idx1), 17);
    chk("multi_const_val", 32'($signed(val1)), 32'h4000);

    // reset during SCAN of word 0, then a clean rescan
    for (int i = 0; i < 16; i++) set0(i, i);
    set0(9, 32'h7FFF);
    scan("abort", 0, 5, 0, 0);
    scan("after_abort", 0, 0, 0, 5);

    // start pulsed while busy; tie at lanes 0 and 7
    for (int i = 0; i < 16; i++) set0(i, -i);
    set0(0, 500);
    set0(7, 500);
    scan("stray", 0, 0, 5, 30);

    // back-to-back on the multi-word instance
    for (int g = 0; g < 32; g++) set1(g, $urandom);
    scan("b2b_a", 1, 0, 0, 0);
    for (int g = 0; g < 32; g++) set1(g, -32768);
    set1(19, -32767);
    scan("b2b_b", 1, 0, 0, 5);

    // random multi-word scans
    for (int r = 0; r < 3; r++) begin
      for (int g = 0; g < 32; g++) set1(g, $urandom_range(0, 15) - 8);
      scan("rand", 1, 0, 0, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
